// File: rtl/hdmi_i2c_pkg.sv
// rtl/hdmi_i2c_pkg.sv - shared I2C target state encodings and bus constants
//
// Purpose: FSM state codes (also driven onto state_out for LEDs/debug), the
// HDMI transmitter bus address bytes and the I2C acknowledge bit levels.
package hdmi_i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'h0,
    ST_DEV       = 4'h1,
    ST_DEV_ACK   = 4'h2,
    ST_PTR       = 4'h3,
    ST_PTR_ACK   = 4'h4,
    ST_WDATA     = 4'h5,
    ST_WDATA_ACK = 4'h6,
    ST_RDATA     = 4'h7,
    ST_RDATA_ACK = 4'h8,
    ST_IGNORE    = 4'h9
  } i2c_state_e;

  localparam logic [7:0] ADV_WR_ADDR = 8'h72;
  localparam logic [7:0] ADV_RD_ADDR = 8'h73;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

endpackage

// File: rtl/i2c_line_filter.sv
// rtl/i2c_line_filter.sv - synchronizer, glitch filter and edge pulses for one I2C line
//
// Purpose: brings an asynchronous SCL or SDA line into clk_ref, rejects pulses
// shorter than FILTER_LEN samples and reports clean level changes.
// Ports:
//   clk_ref   in  system clock
//   reset_not in  asynchronous active-low reset
//   line_in   in  raw bus line
//   level     out filtered line level
//   rise      out 1-cycle pulse when level goes 0->1
//   fall      out 1-cycle pulse when level goes 1->0
module i2c_line_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk_ref,
  input  logic reset_not,
  input  logic line_in,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic          sync_q1;
  logic          sync_q2;
  logic [CW-1:0] cnt;

  // Line state registers reset to the idle-bus level (high) so that leaving
  // reset never produces a phantom edge.
  always_ff @(posedge clk_ref or negedge reset_not) begin
    if (!reset_not) begin
      sync_q1 <= 1'b1;
      sync_q2 <= 1'b1;
      level   <= 1'b1;
      cnt     <= '0;
      rise    <= 1'b0;
      fall    <= 1'b0;
    end else begin
      sync_q1 <= line_in;
      sync_q2 <= sync_q1;
      rise    <= 1'b0;
      fall    <= 1'b0;
      // cnt counts consecutive samples that disagree with the accepted level;
      // any agreeing sample restarts the run.
      if (sync_q2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_LEN - 1)) begin
        level <= sync_q2;
        rise  <= sync_q2;
        fall  <= ~sync_q2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_target_regfile.sv
// rtl/i2c_target_regfile.sv - I2C target with an internal 8-bit register file
//
// Purpose: responds to DEV_ADDR on the I2C bus, writes bytes into reg[] at an
// auto-incrementing pointer and answers reads from it.
// Ports:
//   clk_ref   in    system clock
//   reset_not in    asynchronous active-low reset
//   i2c_scl   in    bus clock (never stretched)
//   i2c_sda   inout bus data, open drain (0 or z)
//   rd_addr   in    host-side read index
//   rd_data   out   reg[rd_addr], combinational
//   wr_strobe out   1-cycle pulse per byte written from the bus
//   wr_addr   out   register index written (valid with wr_strobe)
//   wr_data   out   byte written (valid with wr_strobe)
//   busy      out   address matched, until STOP
//   state_out out   current FSM state
module i2c_target_regfile
  import hdmi_i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR   = 7'h39,
  parameter int         REG_COUNT  = 256,
  parameter int         FILTER_LEN = 4
) (
  input  logic       clk_ref,
  input  logic       reset_not,
  input  logic       i2c_scl,
  inout  wire        i2c_sda,
  input  logic [7:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       wr_strobe,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy,
  output logic [3:0] state_out
);

  localparam int AW = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;

  function automatic logic in_range(input logic [7:0] p);
    return {24'd0, p} < 32'(REG_COUNT);
  endfunction

  function automatic logic [7:0] ptr_inc(input logic [7:0] p);
    if ({24'd0, p} + 32'd1 >= 32'(REG_COUNT)) return 8'h00;
    return p + 8'd1;
  endfunction

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
    .clk_ref(clk_ref), .reset_not(reset_not), .line_in(i2c_scl),
    .level(scl_lvl), .rise(scl_rise), .fall(scl_fall)
  );

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
    .clk_ref(clk_ref), .reset_not(reset_not), .line_in(i2c_sda),
    .level(sda_lvl), .rise(sda_rise), .fall(sda_fall)
  );

  i2c_state_e state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shreg_q, shreg_d;
  logic [7:0] ptr_q, ptr_d;
  logic       sda_low_q, sda_low_d;
  logic       busy_q, busy_d;
  logic       strobe_d;
  logic [7:0] wr_addr_d, wr_data_d;
  logic       reg_we;
  logic [7:0] regs [REG_COUNT];

  wire        start_cond = sda_fall & scl_lvl;
  wire        stop_cond  = sda_rise & scl_lvl;
  wire  [7:0] byte_in    = {shreg_q[6:0], sda_lvl};
  wire  [7:0] ptr_byte   = in_range(ptr_q) ? regs[ptr_q[AW-1:0]] : 8'h00;

  assign i2c_sda   = sda_low_q ? 1'b0 : 1'bz;
  assign rd_data   = in_range(rd_addr) ? regs[rd_addr[AW-1:0]] : 8'h00;
  assign busy      = busy_q;
  assign state_out = state_q;

  always_ff @(posedge clk_ref or negedge reset_not) begin
    if (!reset_not) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      ptr_q     <= '0;
      sda_low_q <= 1'b0;
      busy_q    <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      ptr_q     <= ptr_d;
      sda_low_q <= sda_low_d;
      busy_q    <= busy_d;
      wr_strobe <= strobe_d;
      wr_addr   <= wr_addr_d;
      wr_data   <= wr_data_d;
    end
  end

  always_ff @(posedge clk_ref or negedge reset_not) begin
    if (!reset_not) begin
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= 8'h00;
    end else if (reg_we) begin
      regs[ptr_q[AW-1:0]] <= byte_in;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    ptr_d     = ptr_q;
    sda_low_d = sda_low_q;
    busy_d    = busy_q;
    strobe_d  = 1'b0;
    wr_addr_d = wr_addr;
    wr_data_d = wr_data;
    reg_we    = 1'b0;

    if (start_cond) begin
      state_d   = ST_DEV;
      bit_cnt_d = '0;
      sda_low_d = 1'b0;
    end else if (stop_cond) begin
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
      sda_low_d = 1'b0;
      busy_d    = 1'b0;
    end else begin
      case (state_q)
        ST_DEV, ST_PTR, ST_WDATA: begin
          if (scl_rise) begin
            shreg_d   = byte_in;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = '0;
              if (state_q == ST_DEV) begin
                if (byte_in[7:1] == DEV_ADDR) begin
                  state_d = ST_DEV_ACK;
                  busy_d  = 1'b1;
                end else begin
                  state_d = ST_IGNORE;
                end
              end else if (state_q == ST_PTR) begin
                ptr_d   = byte_in;
                state_d = ST_PTR_ACK;
              end else begin
                // Out-of-range indices are still ACKed and strobed, just not stored.
                reg_we    = in_range(ptr_q);
                strobe_d  = 1'b1;
                wr_addr_d = ptr_q;
                wr_data_d = byte_in;
                ptr_d     = ptr_inc(ptr_q);
                state_d   = ST_WDATA_ACK;
              end
            end
          end
        end

        // First SCL fall after the 8th bit pulls SDA low, the next one ends the ACK.
        ST_DEV_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
          if (scl_fall) begin
            if (!sda_low_q) begin
              sda_low_d = 1'b1;
            end else begin
              sda_low_d = 1'b0;
              bit_cnt_d = '0;
              if (state_q == ST_DEV_ACK && shreg_q[0]) begin
                shreg_d   = ptr_byte;
                sda_low_d = ~ptr_byte[7];
                state_d   = ST_RDATA;
              end else if (state_q == ST_DEV_ACK) begin
                state_d = ST_PTR;
              end else begin
                state_d = ST_WDATA;
              end
            end
          end
        end

        // The MSB is already on the bus when RDATA is entered; each fall after a
        // master sample presents the next bit, the fall after bit 8 releases SDA.
        ST_RDATA: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              sda_low_d = 1'b0;
              bit_cnt_d = '0;
              state_d   = ST_RDATA_ACK;
            end else begin
              shreg_d   = {shreg_q[6:0], 1'b0};
              sda_low_d = ~shreg_q[6];
            end
          end
        end

        // Entered on a fall, so any later fall follows the master's ACK sample.
        ST_RDATA_ACK: begin
          if (scl_rise) begin
            ptr_d = ptr_inc(ptr_q);
            if (sda_lvl == I2C_NACK) state_d = ST_IGNORE;
          end else if (scl_fall) begin
            shreg_d   = ptr_byte;
            sda_low_d = ~ptr_byte[7];
            bit_cnt_d = '0;
            state_d   = ST_RDATA;
          end
        end

        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_target_regfile.sv
// tb/tb_i2c_target_regfile.sv - self-checking bench for i2c_target_regfile
module tb_i2c_target_regfile;
  import hdmi_i2c_pkg::*;

  localparam int H = 24;
  localparam int Q = 12;

  logic       clk_ref = 1'b0;
  logic       reset_not = 1'b0;
  logic       scl = 1'b1;
  logic       sda_drv_low = 1'b0;
  logic [7:0] rd_addr = 8'h00;
  logic [7:0] rd_data;
  logic       wr_strobe;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;
  logic [3:0] state_out;
  wire        sda;

  assign sda = sda_drv_low ? 1'b0 : 1'bz;
  pullup (sda);

  always #10 clk_ref = ~clk_ref;

  i2c_target_regfile dut (
    .clk_ref(clk_ref), .reset_not(reset_not), .i2c_scl(scl), .i2c_sda(sda),
    .rd_addr(rd_addr), .rd_data(rd_data), .wr_strobe(wr_strobe),
    .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .state_out(state_out)
  );

  int          n_tests = 0;
  int          n_fail = 0;
  logic [7:0]  m_regs [256];
  logic [15:0] strobe_q [$];
  logic [7:0]  wbuf [8];
  int          wlen;

  always @(negedge clk_ref) if (wr_strobe === 1'b1) strobe_q.push_back({wr_addr, wr_data});

  initial begin
    repeat (200000) @(posedge clk_ref);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "timeout");
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk_ref);
  endtask

  task automatic i2c_start();
    sda_drv_low = 1'b0; wait_clks(Q);
    scl = 1'b1;         wait_clks(Q);
    sda_drv_low = 1'b1; wait_clks(Q);
    scl = 1'b0;         wait_clks(Q);
  endtask

  task automatic i2c_stop();
    sda_drv_low = 1'b1; wait_clks(Q);
    scl = 1'b1;         wait_clks(Q);
    sda_drv_low = 1'b0; wait_clks(H);
  endtask

  task automatic send_bit(input logic b, input logic glitch);
    sda_drv_low = ~b; wait_clks(Q);
    scl = 1'b1;       wait_clks(H / 2);
    if (glitch) begin
      sda_drv_low = 1'b0; wait_clks(2);
      sda_drv_low = 1'b1; wait_clks(H / 2 - 2);
    end else begin
      wait_clks(H / 2);
    end
    scl = 1'b0; wait_clks(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, input int glitch_bit, output logic ack);
    for (int i = 0; i < 8; i++) send_bit(b[7-i], i == glitch_bit);
    sda_drv_low = 1'b0; wait_clks(Q);
    scl = 1'b1;         wait_clks(H / 2);
    ack = sda;          wait_clks(H / 2);
    scl = 1'b0;         wait_clks(Q);
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] d);
    for (int i = 0; i < 8; i++) begin
      sda_drv_low = 1'b0; wait_clks(Q);
      scl = 1'b1;         wait_clks(H / 2);
      d = {d[6:0], sda};  wait_clks(H / 2);
      scl = 1'b0;         wait_clks(Q);
    end
    sda_drv_low = ~nack; wait_clks(Q);
    scl = 1'b1;          wait_clks(H);
    scl = 1'b0;          wait_clks(Q);
    sda_drv_low = 1'b0;
  endtask

  // START, dev byte, pointer, wbuf[0..wlen-1], STOP; ack bit i = ack of byte i.
  task automatic bus_write(input logic [7:0] dev, input logic [7:0] ptr, output logic [9:0] acks);
    logic a;
    acks = '1;
    i2c_start();
    send_byte(dev, -1, a); acks[0] = a;
    send_byte(ptr, -1, a); acks[1] = a;
    for (int i = 0; i < wlen; i++) begin
      send_byte(wbuf[i], -1, a); acks[2+i] = a;
    end
    i2c_stop();
  endtask

  task automatic model_write(input logic [7:0] ptr);
    for (int i = 0; i < wlen; i++) m_regs[(int'(ptr) + i) % 256] = wbuf[i];
  endtask

  task automatic test_reset();
    reset_not = 1'b0;
    wait_clks(3);
    n_tests++; if (state_out !== 4'(ST_IDLE)) begin n_fail++; $display("FAIL reset_state: got %h expected %h", state_out, 4'(ST_IDLE)); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_tests++; if (wr_strobe !== 1'b0) begin n_fail++; $display("FAIL reset_strobe: got %b expected 0", wr_strobe); end
    n_tests++; if (sda !== 1'b1) begin n_fail++; $display("FAIL reset_sda: got %b expected released", sda); end
    rd_addr = 8'($urandom_range(0, 255)); #1;
    n_tests++; if (rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_reg: got %h expected 00", rd_data); end
    reset_not = 1'b1;
    wait_clks(10);
  endtask

  task automatic test_single_write();
    logic [9:0] acks;
    strobe_q.delete();
    wbuf[0] = 8'h10; wlen = 1;
    bus_write(ADV_WR_ADDR, 8'h41, acks);
    model_write(8'h41);
    n_tests++; if (acks[2:0] !== 3'b000) begin n_fail++; $display("FAIL single_acks: got %b expected 000", acks[2:0]); end
    rd_addr = 8'h41; #1;
    n_tests++; if (rd_data !== m_regs[8'h41]) begin n_fail++; $display("FAIL single_reg: got %h expected %h", rd_data, m_regs[8'h41]); end
    n_tests++; if (strobe_q.size() != 1) begin n_fail++; $display("FAIL single_strobe_count: got %0d expected 1", strobe_q.size()); end
    else begin
      n_tests++; if (strobe_q[0] !== 16'h4110) begin n_fail++; $display("FAIL single_strobe: got %h expected 4110", strobe_q[0]); end
    end
    n_tests++; if (busy !== 1'b0 || state_out !== 4'(ST_IDLE)) begin n_fail++; $display("FAIL single_idle: got busy=%b state=%h expected 0/%h", busy, state_out, 4'(ST_IDLE)); end
  endtask

  task automatic test_wrong_addr();
    logic [9:0] acks;
    logic [7:0] p;
    strobe_q.delete();
    p = 8'($urandom_range(0, 255));
    wbuf[0] = 8'($urandom); wlen = 1;
    bus_write(8'h70, p, acks);
    n_tests++; if (acks[2:0] !== 3'b111) begin n_fail++; $display("FAIL wrong_acks: got %b expected 111", acks[2:0]); end
    n_tests++; if (strobe_q.size() != 0) begin n_fail++; $display("FAIL wrong_strobes: got %0d expected 0", strobe_q.size()); end
    rd_addr = p; #1;
    n_tests++; if (rd_data !== m_regs[p]) begin n_fail++; $display("FAIL wrong_reg: got %h expected %h", rd_data, m_regs[p]); end
  endtask

  task automatic test_burst_wrap();
    logic [9:0] acks;
    strobe_q.delete();
    wbuf[0] = 8'hAA; wbuf[1] = 8'hBB; wbuf[2] = 8'hCC; wlen = 3;
    bus_write(ADV_WR_ADDR, 8'hFE, acks);
    model_write(8'hFE);
    n_tests++; if (acks[4:0] !== 5'b0) begin n_fail++; $display("FAIL burst_acks: got %b expected 00000", acks[4:0]); end
    for (int i = 0; i < 3; i++) begin
      rd_addr = 8'((254 + i) % 256); #1;
      n_tests++; if (rd_data !== m_regs[rd_addr]) begin n_fail++; $display("FAIL burst_reg%0d: got %h expected %h", i, rd_data, m_regs[rd_addr]); end
    end
    n_tests++; if (strobe_q.size() != 3) begin n_fail++; $display("FAIL burst_strobe_count: got %0d expected 3", strobe_q.size()); end
    else begin
      n_tests++; if (strobe_q[2] !== 16'h00CC) begin n_fail++; $display("FAIL burst_strobe_wrap: got %h expected 00CC", strobe_q[2]); end
    end
  endtask

  task automatic test_read_rs();
    logic [9:0] acks;
    logic       a;
    logic [7:0] d;
    for (int i = 0; i < 3; i++) wbuf[i] = 8'($urandom_range(1, 255));
    wlen = 3;
    bus_write(ADV_WR_ADDR, 8'h16, acks);
    model_write(8'h16);
    strobe_q.delete();
    i2c_start();
    send_byte(ADV_WR_ADDR, -1, a);
    send_byte(8'h16, -1, a);
    i2c_start();
    send_byte(ADV_RD_ADDR, -1, a);
    n_tests++; if (a !== I2C_ACK) begin n_fail++; $display("FAIL read_addr_ack: got %b expected 0", a); end
    recv_byte(1'b0, d);
    n_tests++; if (d !== m_regs[8'h16]) begin n_fail++; $display("FAIL read_byte0: got %h expected %h", d, m_regs[8'h16]); end
    recv_byte(1'b1, d);
    n_tests++; if (d !== m_regs[8'h17]) begin n_fail++; $display("FAIL read_byte1: got %h expected %h", d, m_regs[8'h17]); end
    i2c_stop();
    i2c_start();
    send_byte(ADV_RD_ADDR, -1, a);
    recv_byte(1'b1, d);
    i2c_stop();
    n_tests++; if (d !== m_regs[8'h18]) begin n_fail++; $display("FAIL read_ptr_end: got %h expected %h", d, m_regs[8'h18]); end
    n_tests++; if (strobe_q.size() != 0) begin n_fail++; $display("FAIL read_strobes: got %0d expected 0", strobe_q.size()); end
  endtask

  task automatic test_glitch();
    logic       a;
    logic [7:0] p, v;
    logic [2:0] acks;
    sda_drv_low = 1'b1; wait_clks(2);
    sda_drv_low = 1'b0; wait_clks(20);
    n_tests++; if (state_out !== 4'(ST_IDLE)) begin n_fail++; $display("FAIL glitch_start: got %h expected %h", state_out, 4'(ST_IDLE)); end
    strobe_q.delete();
    p = 8'($urandom_range(0, 127));
    v = 8'($urandom);
    i2c_start();
    send_byte(ADV_WR_ADDR, -1, a); acks[0] = a;
    send_byte(p, 0, a);            acks[1] = a;
    send_byte(v, -1, a);           acks[2] = a;
    i2c_stop();
    m_regs[p] = v;
    n_tests++; if (acks !== 3'b000) begin n_fail++; $display("FAIL glitch_acks: got %b expected 000", acks); end
    rd_addr = p; #1;
    n_tests++; if (rd_data !== m_regs[p]) begin n_fail++; $display("FAIL glitch_reg: got %h expected %h", rd_data, m_regs[p]); end
    n_tests++; if (strobe_q.size() != 1) begin n_fail++; $display("FAIL glitch_strobes: got %0d expected 1", strobe_q.size()); end
  endtask

  task automatic test_stop_mid_byte();
    logic       a;
    logic [9:0] acks;
    strobe_q.delete();
    i2c_start();
    send_byte(ADV_WR_ADDR, -1, a);
    send_byte(8'h41, -1, a);
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
    i2c_stop();
    n_tests++; if (strobe_q.size() != 0) begin n_fail++; $display("FAIL stopmid_strobes: got %0d expected 0", strobe_q.size()); end
    rd_addr = 8'h41; #1;
    n_tests++; if (rd_data !== m_regs[8'h41]) begin n_fail++; $display("FAIL stopmid_reg: got %h expected %h", rd_data, m_regs[8'h41]); end
    n_tests++; if (state_out !== 4'(ST_IDLE)) begin n_fail++; $display("FAIL stopmid_state: got %h expected %h", state_out, 4'(ST_IDLE)); end
    wbuf[0] = 8'h55; wlen = 1;
    bus_write(ADV_WR_ADDR, 8'h41, acks);
    model_write(8'h41);
    #1;
    n_tests++; if (rd_data !== 8'h55) begin n_fail++; $display("FAIL stopmid_rewrite: got %h expected 55", rd_data); end
    n_tests++; if (strobe_q.size() != 1) begin n_fail++; $display("FAIL stopmid_rewrite_strobes: got %0d expected 1", strobe_q.size()); end
  endtask

  task automatic test_random();
    logic [9:0] acks;
    logic [7:0] p, d;
    logic       a;
    for (int it = 0; it < 4; it++) begin
      strobe_q.delete();
      p = 8'($urandom);
      wlen = int'($urandom_range(1, 3));
      for (int i = 0; i < wlen; i++) wbuf[i] = 8'($urandom);
      bus_write(ADV_WR_ADDR, p, acks);
      model_write(p);
      n_tests++; if (acks[wlen+1 -: 3] !== 3'b000 || acks[1:0] !== 2'b00) begin n_fail++; $display("FAIL rand_acks%0d: got %b expected all 0", it, acks); end
      n_tests++; if (strobe_q.size() != wlen) begin n_fail++; $display("FAIL rand_strobe_count%0d: got %0d expected %0d", it, strobe_q.size(), wlen); end
      else for (int i = 0; i < wlen; i++) begin
        n_tests++;
        if (strobe_q[i] !== {8'((int'(p) + i) % 256), wbuf[i]}) begin
          n_fail++; $display("FAIL rand_strobe%0d_%0d: got %h expected %h", it, i, strobe_q[i], {8'((int'(p) + i) % 256), wbuf[i]});
        end
      end
      for (int i = 0; i < wlen; i++) begin
        rd_addr = 8'((int'(p) + i) % 256); #1;
        n_tests++; if (rd_data !== m_regs[rd_addr]) begin n_fail++; $display("FAIL rand_host%0d_%0d: got %h expected %h", it, i, rd_data, m_regs[rd_addr]); end
      end
      i2c_start();
      send_byte(ADV_WR_ADDR, -1, a);
      send_byte(p, -1, a);
      i2c_start();
      send_byte(ADV_RD_ADDR, -1, a);
      for (int i = 0; i < wlen; i++) begin
        recv_byte(i == wlen - 1, d);
        n_tests++; if (d !== m_regs[(int'(p) + i) % 256]) begin n_fail++; $display("FAIL rand_bus%0d_%0d: got %h expected %h", it, i, d, m_regs[(int'(p) + i) % 256]); end
      end
      i2c_stop();
    end
  endtask

  task automatic test_reset_mid();
    logic       a;
    int         bad;
    strobe_q.delete();
    i2c_start();
    send_byte(ADV_WR_ADDR, -1, a);
    send_byte(8'($urandom), -1, a);
    for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b0);
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL resetmid_busy_before: got %b expected 1", busy); end
    reset_not = 1'b0;
    for (int i = 0; i < 256; i++) m_regs[i] = 8'h00;
    wait_clks(2);
    n_tests++; if (sda !== 1'b0) begin n_fail++; $display("FAIL resetmid_sda: got %b expected master-held 0", sda); end
    sda_drv_low = 1'b0; scl = 1'b1; #1;
    n_tests++; if (sda !== 1'b1) begin n_fail++; $display("FAIL resetmid_sda_release: got %b expected released", sda); end
    n_tests++; if (state_out !== 4'(ST_IDLE) || busy !== 1'b0) begin n_fail++; $display("FAIL resetmid_state: got %h/%b expected %h/0", state_out, busy, 4'(ST_IDLE)); end
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      rd_addr = 8'(i); #1;
      if (rd_data !== m_regs[i]) bad++;
    end
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL resetmid_regs: got %0d nonzero registers expected 0", bad); end
    wait_clks(4);
    reset_not = 1'b1;
    wait_clks(20);
    n_tests++; if (strobe_q.size() != 0) begin n_fail++; $display("FAIL resetmid_strobes: got %0d expected 0", strobe_q.size()); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) m_regs[i] = 8'h00;
    test_reset();
    test_single_write();
    test_wrong_addr();
    test_burst_wrap();
    test_read_rs();
    test_glitch();
    test_stop_mid_byte();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
